// File: rtl/dec_vec_issue_q_pkg.sv
// ============================================================================
// Module  : dec_vec_issue_q_pkg
// Purpose : Shared types for the vector issue queue: the op-class encoding,
//           the formatted issue packet and a small class helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dec_vec_issue_q_pkg;

  // Issue packet width; fixed by the struct layout below.
  localparam int PW = 57;

  typedef enum logic [2:0] {
    VV  = 3'd0,
    XV  = 3'd1,
    VI  = 3'd2,
    VX  = 3'd3,
    VLD = 3'd4,
    VST = 3'd5
  } vec_cls_t;

  // Field order is MSB to LSB.
  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [5:0]  funct6;
    logic        vm;
    logic [31:0] scalar;
  } vec_issue_pkt_t;

  // True for the classes that touch memory (vload / vstore).
  function automatic logic is_mem_cls(input logic [2:0] cls);
    return (cls == VLD) || (cls == VST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_vec_issue_q_fifo.sv
// ============================================================================
// Module  : dec_vec_fifo
// Purpose : Generic in-order DEPTH x PW FIFO with wrapping pointers, an
//           occupancy count and a synchronous flush. Storage is not reset.
// Ports   : clk, rst_l        - clock, async active-low reset
//           i_flush           - clear pointers and count next cycle
//           i_push / i_wdata  - write one entry (caller guarantees not full)
//           i_pop             - retire the head (caller guarantees not empty)
//           o_rdata           - head entry
//           o_count           - occupancy, o_full / o_empty flags
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dec_vec_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = 57
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [PW-1:0]            i_wdata,
  input  logic                     i_pop,
  output logic [PW-1:0]            o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers are exactly AW bits, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Data array has no reset; a flushed write is simply never exposed.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/dec_vec_issue_q.sv
// ============================================================================
// Module  : dec_vec_issue_q
// Purpose : Issue queue between the decoder and the vector execution unit.
//           Formats decoded vector instructions into vec_issue_pkt_t, buffers
//           them in order and issues over valid/ready. Tracks pending vector
//           memory ops for the LSU and pulses vq_illegal on class 6/7.
// Config  : RV_VEC_BYPASS_EN - when defined, an empty queue forwards the
//           incoming packet to the vector unit in the same cycle.
// Ports   : clk, rst_l                      - clock, async active-low reset
//           dec_vq_valid/class/instr/rs1_data - decoder request
//           dec_tlu_flush_lower_wb          - pipeline flush
//           vq_dec_stall                    - queue full, decoder holds
//           vq_vu_valid/vq_vu_pkt, vu_vq_ready - issue handshake
//           vq_lsu_mem_pend                 - vload/vstore still queued
//           vq_count                        - occupancy
//           vq_illegal                      - one-cycle illegal-class pulse
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dec_vec_issue_q
  import dec_vec_issue_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    dec_vq_valid,
  input  logic [2:0]              dec_vq_class,
  input  logic [31:0]             dec_vq_instr,
  input  logic [31:0]             dec_vq_rs1_data,
  input  logic                    dec_tlu_flush_lower_wb,
  output logic                    vq_dec_stall,
  output logic                    vq_vu_valid,
  output vec_issue_pkt_t          vq_vu_pkt,
  input  logic                    vu_vq_ready,
  output logic                    vq_lsu_mem_pend,
  output logic [$clog2(DEPTH):0]  vq_count,
  output logic                    vq_illegal
);

  localparam int CW = $clog2(DEPTH) + 1;

  vec_issue_pkt_t w_pkt;
  vec_issue_pkt_t w_head;
  logic           w_legal;
  logic           w_accept;
  logic           w_push_req;
  logic           w_bypass_take;
  logic           w_fifo_push;
  logic           w_fifo_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_mem_inc;
  logic           w_mem_dec;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  r_mem_cnt;
  logic           r_illegal;
  logic           w_unused_instr;

  // Opcode and funct3 are resolved by the decoder and not carried forward.
  assign w_unused_instr = ^{dec_vq_instr[14:12], dec_vq_instr[6:0]};

  // --------------------------------------------------------------------------
  // Packet formatting
  // --------------------------------------------------------------------------
  always_comb begin
    w_pkt        = '0;
    w_pkt.cls    = dec_vq_class;
    w_pkt.vd     = dec_vq_instr[11:7];
    w_pkt.vs1    = dec_vq_instr[19:15];
    w_pkt.vs2    = dec_vq_instr[24:20];
    w_pkt.funct6 = dec_vq_instr[31:26];
    w_pkt.vm     = dec_vq_instr[25];
    if (dec_vq_class == VI)
      w_pkt.scalar = {{27{dec_vq_instr[19]}}, dec_vq_instr[19:15]};
    else if (dec_vq_class == VV)
      w_pkt.scalar = '0;
    else
      w_pkt.scalar = dec_vq_rs1_data;
  end

  // --------------------------------------------------------------------------
  // Push / pop qualification
  // --------------------------------------------------------------------------
  assign w_legal    = (dec_vq_class <= 3'd5);
  assign w_accept   = dec_vq_valid & ~w_full & ~dec_tlu_flush_lower_wb;
  assign w_push_req = w_accept & w_legal;

`ifdef RV_VEC_BYPASS_EN
  logic w_bypass;
  // Bypass only from an empty queue; flush already gates w_push_req.
  assign w_bypass      = w_push_req & w_empty;
  assign w_bypass_take = w_bypass & vu_vq_ready;
  assign vq_vu_valid   = ~w_empty | w_bypass;
  assign vq_vu_pkt     = w_empty ? w_pkt : w_head;
`else
  assign w_bypass_take = 1'b0;
  assign vq_vu_valid   = ~w_empty;
  assign vq_vu_pkt     = w_head;
`endif

  // A bypassed packet consumed this cycle never enters storage.
  assign w_fifo_push = w_push_req & ~w_bypass_take;
  assign w_fifo_pop  = ~w_empty & vu_vq_ready & ~dec_tlu_flush_lower_wb;

  dec_vec_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .i_flush (dec_tlu_flush_lower_wb),
    .i_push  (w_fifo_push),
    .i_wdata (w_pkt),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // --------------------------------------------------------------------------
  // Pending memory-op counter
  // --------------------------------------------------------------------------
  assign w_mem_inc = w_fifo_push & is_mem_cls(w_pkt.cls);
  assign w_mem_dec = w_fifo_pop  & is_mem_cls(w_head.cls);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_mem_cnt <= '0;
    end else if (dec_tlu_flush_lower_wb) begin
      r_mem_cnt <= '0;
    end else begin
      case ({w_mem_inc, w_mem_dec})
        2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
        2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Illegal-class pulse: accepted handshake that carries class 6/7
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_illegal <= 1'b0;
    else        r_illegal <= w_accept & ~w_legal;
  end

  assign vq_dec_stall    = w_full;
  assign vq_count        = w_count;
  assign vq_lsu_mem_pend = (r_mem_cnt != '0);
  assign vq_illegal      = r_illegal;

endmodule

`default_nettype wire

// File: doc/dec_vec_issue_q.md
Name: dec_vec_issue_q

Overview:
- Issue queue between the decoder and the vector execution unit.
- Accepts decoded vector instructions (dec_pkt_t is_vector set), formats them into a vector issue packet, and buffers them in an in-order FIFO.
- Issues to the vector unit over a valid/ready handshake.
- Flushed by TLU lower-flush; also reports pending vector memory ops so the LSU can order scalar accesses.

Parameters:
- DEPTH, 4, queue entries; power of 2, 2..16.
- PW, 57, issue packet width; fixed by vec_issue_pkt_t; not overridable.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- dec_vq_valid  in  1  decoder presents a vector instruction
- dec_vq_class  in  3  op class: 0 vv, 1 xv, 2 vi, 3 vx, 4 vload, 5 vstore, 6/7 illegal
- dec_vq_instr  in  32  raw instruction
- dec_vq_rs1_data  in  32  scalar rs1 operand (xv/vx/vload/vstore)
- dec_tlu_flush_lower_wb  in  1  pipeline flush
- vq_dec_stall  out  1  queue full; decoder must hold
- vq_vu_valid  out  1  head entry valid
- vq_vu_pkt  out  PW  head packet (vec_issue_pkt_t)
- vu_vq_ready  in  1  vector unit accepts head
- vq_lsu_mem_pend  out  1  any vload/vstore queued
- vq_count  out  $clog2(DEPTH)+1  occupancy
- vq_illegal  out  1  one-cycle pulse, illegal class dropped

Behaviour:
- Packet fields, MSB to LSB:
  - cls[2:0]
  - vd = instr[11:7]
  - vs1 = instr[19:15]
  - vs2 = instr[24:20]
  - funct6 = instr[31:26]
  - vm = instr[25]
  - scalar[31:0]: class vi = sign-extended instr[19:15]; class vv = 0; otherwise dec_vq_rs1_data.
- Push = dec_vq_valid & ~vq_dec_stall & ~flush & class<=5.
- Pop = vq_vu_valid & vu_vq_ready & ~flush.
- vq_dec_stall = (count == DEPTH), taken from the registered count. A pop in the same cycle does not unblock a push.
- Class 6/7 with dec_vq_valid & ~stall & ~flush: no write; vq_illegal registered high for 1 cycle.
- Latency: push in cycle N gives vq_vu_valid in cycle N+1 at the earliest.
- Ordering: strictly in order; the head is held stable while vq_vu_valid & ~vu_vq_ready.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count:
  - +1 on push only; -1 on pop only; unchanged on both.
  - Push when full is impossible by construction. Pop when empty is impossible because valid is low.
- mem_cnt:
  - +1 on push of class 4/5; -1 on pop of class 4/5; simultaneous ops net out.
  - vq_lsu_mem_pend = (mem_cnt != 0).
- Flush: the next cycle has pointers = 0, count = 0, mem_cnt = 0, no valid entries. Flush wins over a simultaneous push and pop; both are discarded.
- Reset (rst_l low, async):
  - pointers, count, mem_cnt = 0
  - vq_vu_valid = 0, vq_dec_stall = 0, vq_lsu_mem_pend = 0, vq_illegal = 0, vq_count = 0
  - Storage is not reset; vq_vu_pkt is don't-care while invalid.
- Reset deasserted mid-operation: resume from the empty state; in-flight decoder input during reset is lost.

Optional Feature:
- Macro: RV_VEC_BYPASS_EN.
- Defined:
  - When count == 0 and push, vq_vu_valid is asserted in the same cycle and vq_vu_pkt = the incoming formatted packet (combinational).
  - If vu_vq_ready, the entry is not written; counters are unchanged, with mem_cnt net 0.
  - Flush still blocks the bypass.
- Undefined: no bypass; the minimum push-to-issue latency is 1 cycle.

Decomposition:
- In swerv_types:
  - vec_issue_pkt_t packed struct {cls, vd, vs1, vs2, funct6, vm, scalar}.
  - vec_cls_t enum (VV=0, XV=1, VI=2, VX=3, VLD=4, VST=5).
- Sub-module dec_vec_fifo: generic DEPTH x PW storage, pointers, count, full/empty, flush.
- The top-level holds packet formatting, mem_cnt, the illegal pulse and the bypass.

Test Plan:
- 4 back-to-back vv pushes with vu_vq_ready = 0 -> vq_count 1,2,3,4; stall = 1 after the 4th; a 5th push is held. Raise ready -> pops in order, with vd equal to the pushed vd sequence.
- vi push with instr[19:15] = 5'b10110 -> scalar = 32'hFFFF_FFF6; vx push with rs1_data = 32'h1234_5678 -> scalar = 32'h1234_5678; vv push -> scalar = 0.
- Push vload, vv, vstore -> mem_pend = 1. Pop vload -> still 1. Pop vv -> still 1. Pop vstore -> 0.
- Count = 3 with push, pop and flush in the same cycle -> next cycle count = 0, vq_vu_valid = 0, mem_pend = 0.
- Class 7 with valid -> vq_illegal = 1 for exactly one cycle; count unchanged.
- Bypass (RV_VEC_BYPASS_EN): empty queue, push with ready = 1 -> vq_vu_valid and matching pkt in the same cycle; count stays 0. Without the macro -> valid appears the next cycle and count = 1 for one cycle.
